// File: rtl/shufflev_rng_pkg.sv
// Shared types and constants for the ShuffleV random-word source.
// Holds the generator geometry, feedback taps and reset images.
package shufflev_rng_pkg;

  typedef enum logic [1:0] {
    WARMUP,
    RUN,
    FAIL
  } rng_state_e;

  localparam int LFSR_W = 43;
  localparam int CASR_W = 37;

  // Galois feedback lands on bits 41, 20, 1 and 0
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 43'h200_0010_0003;

  localparam int RULE150_IDX = 27;

  localparam logic [LFSR_W-1:0] LFSR_RESET = 43'd1;
  localparam logic [CASR_W-1:0] CASR_RESET = 37'd1;

endpackage

// File: rtl/shufflev_rng_core.sv
// LFSR + CASR generator core with seed load, step and hold controls.
// The mix word is formed from the current (pre-step) state.
module shufflev_rng_core
  import shufflev_rng_pkg::*;
#(
  parameter int MIX_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic [31:0]      seed,
  output logic [MIX_W-1:0] mix
);

  logic [LFSR_W-1:0] lfsr_reg;
  logic [CASR_W-1:0] casr_reg;
  logic [LFSR_W-1:0] lfsr_step;
  logic [CASR_W-1:0] casr_step;
  logic [LFSR_W-1:0] lfsr_seed;
  logic [CASR_W-1:0] casr_seed;

  assign lfsr_step = {lfsr_reg[LFSR_W-2:0], 1'b0} ^ (lfsr_reg[LFSR_W-1] ? LFSR_TAPS : '0);

  // Cyclic neighbourhood; one cell also keeps its own value (rule 150)
  genvar gi;
  generate
    for (gi = 0; gi < CASR_W; gi++) begin : g_casr
      if (gi == RULE150_IDX) begin : g_r150
        assign casr_step[gi] = casr_reg[(gi+CASR_W-1)%CASR_W] ^ casr_reg[gi]
                             ^ casr_reg[(gi+1)%CASR_W];
      end else begin : g_r90
        assign casr_step[gi] = casr_reg[(gi+CASR_W-1)%CASR_W] ^ casr_reg[(gi+1)%CASR_W];
      end
    end
  endgenerate

  // A zero seed would lock both registers at all-zero
  assign lfsr_seed = (seed == 32'd0) ? LFSR_RESET : {{(LFSR_W-32){1'b0}}, seed};
  assign casr_seed = (seed == 32'd0) ? CASR_RESET : {{(CASR_W-32){1'b0}}, seed};

  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_reg <= LFSR_RESET;
      casr_reg <= CASR_RESET;
    end else if (load) begin
      lfsr_reg <= lfsr_seed;
      casr_reg <= casr_seed;
    end else if (step) begin
      lfsr_reg <= lfsr_step;
      casr_reg <= casr_step;
    end
  end

  assign mix = lfsr_reg[MIX_W-1:0] ^ casr_reg[MIX_W-1:0];

endmodule

// File: rtl/shufflev_rng_stream.sv
// Random-word stream: warm-up sequencing, valid/ready output register
// and a sticky repeated-word health alarm around the generator core.
module shufflev_rng_stream
  import shufflev_rng_pkg::*;
#(
  parameter int OUT_W         = 32,
  parameter int WARMUP_CYCLES = 64,
  parameter int REP_LIMIT     = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             seed_valid_i,
  input  logic [31:0]      seed_i,
  output logic             rnd_valid_o,
  input  logic             rnd_ready_i,
  output logic [OUT_W-1:0] rnd_o,
  output logic             busy_o,
  output logic             alarm_o
);

  localparam int WC_W = $clog2(WARMUP_CYCLES + 1);
  localparam int RC_W = $clog2(REP_LIMIT + 1);

  rng_state_e       state_reg, state_next;
  logic [WC_W-1:0]  wcnt_reg, wcnt_next;
  logic [RC_W-1:0]  rcnt_reg, rcnt_next;
  logic [OUT_W-1:0] prev_reg, prev_next;
  logic             have_prev_reg, have_prev_next;
  logic [OUT_W-1:0] rnd_reg, rnd_next;
  logic             valid_reg, valid_next;
  logic             core_step;
  logic [OUT_W-1:0] word;
  logic             repeat_hit;

  shufflev_rng_core #(.MIX_W(OUT_W)) u_core (
    .clk   (clk),
    .reset (reset),
    .load  (seed_valid_i),
    .step  (core_step),
    .seed  (seed_i),
    .mix   (word)
  );

  assign repeat_hit = have_prev_reg && (word == prev_reg);

  always_comb begin
    state_next     = state_reg;
    wcnt_next      = wcnt_reg;
    rcnt_next      = rcnt_reg;
    prev_next      = prev_reg;
    have_prev_next = have_prev_reg;
    rnd_next       = rnd_reg;
    valid_next     = valid_reg;
    core_step      = 1'b0;

    if (seed_valid_i) begin
      state_next     = WARMUP;
      wcnt_next      = '0;
      rcnt_next      = '0;
      prev_next      = '0;
      have_prev_next = 1'b0;
      valid_next     = 1'b0;
    end else begin
      case (state_reg)
        WARMUP: begin
          core_step = 1'b1;
          if (wcnt_reg == WC_W'(WARMUP_CYCLES - 1)) begin
            state_next = RUN;
          end else begin
            wcnt_next = wcnt_reg + 1'b1;
          end
        end
        RUN: begin
          core_step = 1'b1;
          if (!valid_reg || rnd_ready_i) begin
            prev_next      = word;
            have_prev_next = 1'b1;
            // rcnt counts repeats beyond the first copy of a word
            if (repeat_hit && rcnt_reg == RC_W'(REP_LIMIT - 2)) begin
              state_next = FAIL;
              valid_next = 1'b0;
            end else begin
              rcnt_next  = repeat_hit ? rcnt_reg + 1'b1 : '0;
              rnd_next   = word;
              valid_next = 1'b1;
            end
          end
        end
        FAIL: begin
          valid_next = 1'b0;
        end
        default: begin
          state_next = WARMUP;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= WARMUP;
      wcnt_reg      <= '0;
      rcnt_reg      <= '0;
      prev_reg      <= '0;
      have_prev_reg <= 1'b0;
      rnd_reg       <= '0;
      valid_reg     <= 1'b0;
    end else begin
      state_reg     <= state_next;
      wcnt_reg      <= wcnt_next;
      rcnt_reg      <= rcnt_next;
      prev_reg      <= prev_next;
      have_prev_reg <= have_prev_next;
      rnd_reg       <= rnd_next;
      valid_reg     <= valid_next;
    end
  end

  assign rnd_o       = rnd_reg;
  assign rnd_valid_o = valid_reg;
  assign busy_o      = (state_reg == WARMUP);
  assign alarm_o     = (state_reg == FAIL);

endmodule

// File: tb/tb_shufflev_rng_stream.sv
// Bench for shufflev_rng_stream: a default instance and a tiny health-test
// instance, both checked every cycle against a word-level reference model.
module tb_shufflev_rng_stream;

  typedef struct packed {
    logic [42:0] l;
    logic [36:0] c;
    int          steps;
    bit          valid;
    logic [31:0] rnd;
    bit          alarm;
    bit          have_prev;
    logic [31:0] prev;
    int          same_run;
  } mdl_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        seed_valid_a, seed_valid_b;
  logic [31:0] seed_a, seed_b;
  logic        ready_a, ready_b;
  logic        valid_a, valid_b;
  logic [31:0] rnd_a;
  logic [0:0]  rnd_b;
  logic        busy_a, busy_b, alarm_a, alarm_b;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  bit   verbose = 1'b1;
  mdl_t ma, mb;

  always #5 clk = ~clk;

  shufflev_rng_stream dut_a (
    .clk          (clk),
    .reset        (reset),
    .seed_valid_i (seed_valid_a),
    .seed_i       (seed_a),
    .rnd_valid_o  (valid_a),
    .rnd_ready_i  (ready_a),
    .rnd_o        (rnd_a),
    .busy_o       (busy_a),
    .alarm_o      (alarm_a)
  );

  shufflev_rng_stream #(.OUT_W(1), .WARMUP_CYCLES(1), .REP_LIMIT(2)) dut_b (
    .clk          (clk),
    .reset        (reset),
    .seed_valid_i (seed_valid_b),
    .seed_i       (seed_b),
    .rnd_valid_o  (valid_b),
    .rnd_ready_i  (ready_b),
    .rnd_o        (rnd_b),
    .busy_o       (busy_b),
    .alarm_o      (alarm_b)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [42:0] lfsr_next(input logic [42:0] l);
    logic [42:0] n;
    logic f;
    f = l[42];
    n[0] = f;
    for (int i = 1; i < 43; i++) n[i] = l[i-1];
    n[1]  = l[0] ^ f;
    n[20] = l[19] ^ f;
    n[41] = l[40] ^ l[42];
    return n;
  endfunction

  function automatic logic [36:0] casr_next(input logic [36:0] c);
    logic [36:0] n;
    for (int i = 0; i < 37; i++) n[i] = c[(i + 36) % 37] ^ c[(i + 1) % 37];
    n[27] = n[27] ^ c[27];
    return n;
  endfunction

  // Word-level behaviour: steps since load, output slot, run length of equal words
  function automatic mdl_t model_edge(input mdl_t m, input bit rst, input bit sv,
                                      input logic [31:0] seed, input bit rdy,
                                      input int warm, input int outw, input int rep);
    mdl_t n;
    logic [31:0] mask, w;
    n = m;
    mask = 32'((64'd1 << outw) - 64'd1);
    if (rst || sv) begin
      if (rst || seed == 32'd0) begin
        n.l = 43'd1;
        n.c = 37'd1;
      end else begin
        n.l = {11'b0, seed};
        n.c = {5'b0, seed};
      end
      n.steps = 0; n.valid = 1'b0; n.alarm = 1'b0;
      n.have_prev = 1'b0; n.prev = '0; n.same_run = 0;
      if (rst) n.rnd = '0;
      return n;
    end
    if (m.alarm) return n;
    if (m.steps >= warm && (!m.valid || rdy)) begin
      w = (m.l[31:0] ^ m.c[31:0]) & mask;
      n.same_run = (m.have_prev && w == m.prev) ? m.same_run + 1 : 1;
      n.prev = w;
      n.have_prev = 1'b1;
      if (n.same_run >= rep) begin
        n.alarm = 1'b1;
        n.valid = 1'b0;
      end else begin
        n.valid = 1'b1;
        n.rnd = w;
      end
    end
    n.l = lfsr_next(m.l);
    n.c = casr_next(m.c);
    if (m.steps < warm) n.steps = m.steps + 1;
    return n;
  endfunction

  task automatic tick();
    mdl_t na, nb;
    na = model_edge(ma, reset, seed_valid_a, seed_a, ready_a, 64, 32, 4);
    nb = model_edge(mb, reset, seed_valid_b, seed_b, ready_b, 1, 1, 2);
    if (verbose && !reset && valid_a && ready_a)
      $display("xfer a cycle %0d word %h", cyc, rnd_a);
    @(posedge clk);
    #1;
    ma = na;
    mb = nb;
    cyc++;
    check_eq("a_valid", {31'b0, valid_a}, {31'b0, ma.valid});
    check_eq("a_busy", {31'b0, busy_a}, {31'b0, !ma.alarm && ma.steps < 64});
    check_eq("a_alarm", {31'b0, alarm_a}, {31'b0, ma.alarm});
    if (ma.valid) check_eq("a_rnd", rnd_a, ma.rnd);
    check_eq("b_valid", {31'b0, valid_b}, {31'b0, mb.valid});
    check_eq("b_busy", {31'b0, busy_b}, {31'b0, !mb.alarm && mb.steps < 1});
    check_eq("b_alarm", {31'b0, alarm_b}, {31'b0, mb.alarm});
    if (mb.valid) check_eq("b_rnd", {31'b0, rnd_b}, mb.rnd);
  endtask

  // Counts edges from now until valid rises on instance a (bounded)
  task automatic measure_latency(input string tag);
    int n, busy_low;
    n = 0;
    busy_low = -1;
    while (n < 200) begin
      tick();
      n++;
      if (!busy_a && busy_low < 0) busy_low = n;
      if (valid_a) break;
    end
    check_eq({tag, "_valid_lat"}, n, 65);
    check_eq({tag, "_busy_lat"}, busy_low, 64);
  endtask

  initial begin
    logic [31:0] first_word, hold_word;
    int n;
    reset = 1'b1;
    seed_valid_a = 1'b0; seed_valid_b = 1'b0;
    seed_a = '0; seed_b = '0;
    ready_a = 1'b1; ready_b = 1'b1;
    ma = '0; mb = '0;
    tick();
    tick();
    check_eq("rst_rnd_a", rnd_a, 32'd0);
    check_eq("rst_busy_a", {31'b0, busy_a}, 32'd1);

    // Reset release with ready held high
    reset = 1'b0;
    measure_latency("t1");
    first_word = ma.rnd;
    repeat (20) tick();

    // Zero seed reproduces the reset stream
    seed_valid_a = 1'b1; seed_a = 32'd0;
    tick();
    seed_valid_a = 1'b0;
    measure_latency("zero_seed");
    check_eq("zero_seed_word", rnd_a, first_word);
    repeat (10) tick();

    // Backpressure after seeding 0xDEADBEEF
    seed_valid_a = 1'b1; seed_a = 32'hDEADBEEF;
    tick();
    seed_valid_a = 1'b0;
    measure_latency("bp");
    hold_word = ma.rnd;
    ready_a = 1'b0;
    repeat (10) begin
      tick();
      check_eq("bp_hold_word", rnd_a, hold_word);
      check_eq("bp_hold_valid", {31'b0, valid_a}, 32'd1);
    end
    ready_a = 1'b1;
    repeat (5) tick();

    // Seed strobe mid-stream together with a handshake
    seed_valid_a = 1'b1; seed_a = 32'h1234_5678;
    tick();
    seed_valid_a = 1'b0;
    check_eq("mid_valid", {31'b0, valid_a}, 32'd0);
    check_eq("mid_busy", {31'b0, busy_a}, 32'd1);
    repeat (70) tick();

    // Health alarm on the 1-bit instance
    seed_valid_b = 1'b1; seed_b = $urandom | 32'd1;
    tick();
    seed_valid_b = 1'b0;
    n = 0;
    while (!alarm_b && n < 300) begin
      tick();
      n++;
    end
    check_eq("b_alarm_seen", {31'b0, alarm_b}, 32'd1);
    check_eq("b_alarm_valid", {31'b0, valid_b}, 32'd0);
    repeat (5) tick();
    check_eq("b_alarm_sticky", {31'b0, alarm_b}, 32'd1);
    seed_valid_b = 1'b1; seed_b = $urandom;
    tick();
    seed_valid_b = 1'b0;
    check_eq("b_alarm_clear", {31'b0, alarm_b}, 32'd0);

    // Reset during warm-up
    seed_valid_a = 1'b1; seed_a = $urandom;
    tick();
    seed_valid_a = 1'b0;
    repeat (30) tick();
    reset = 1'b1;
    tick();
    check_eq("rst30_rnd", rnd_a, 32'd0);
    check_eq("rst30_valid", {31'b0, valid_a}, 32'd0);
    check_eq("rst30_busy", {31'b0, busy_a}, 32'd1);
    check_eq("rst30_alarm_b", {31'b0, alarm_b}, 32'd0);
    reset = 1'b0;
    measure_latency("rst30");

    // Randomized traffic, seeds and occasional reset
    verbose = 1'b0;
    repeat (3000) begin
      ready_a = ($urandom_range(0, 3) != 0);
      ready_b = ($urandom_range(0, 3) != 0);
      seed_valid_a = ($urandom_range(0, 299) == 0);
      seed_a = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      seed_valid_b = ($urandom_range(0, 39) == 0);
      seed_b = $urandom;
      reset = ($urandom_range(0, 1999) == 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
